driver_column_shifter: RTL
==========================

# driver_column_shifter

Downstream consumer of the column framebuffer. Serializes one 384-bit column word (16 pixels × 24-bit RGB) onto 16 parallel LED-driver data lines, one pixel per driver. Each 8-bit colour is expanded to 16-bit grayscale. The block generates the shared shift clock and latch, then pulses `EOC` so the framebuffer swaps its buffers. It sends `MULTIPLEXING` columns per frame, starting on the framebuffer's `driver_SOF`.

## Interface
Parameters:
- `NB_DRIVERS`, 16, number of drivers; `data_in` width is 24·`NB_DRIVERS`.
- `MULTIPLEXING`, 8, columns per frame.
- `SCLK_DIV`, 2, `drv_sclk` half-period in `clk` cycles (≥1).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  384  column from the framebuffer; driver d owns bits [24d+23:24d] = {R[7:0],G[7:0],B[7:0]}.
- `driver_SOF`  in  1  one-cycle pulse: first column of a frame is ready.
- `EOC`  out  1  one-cycle pulse: current column fully shifted and latched.
- `frame_done`  out  1  one-cycle pulse, coincident with the last column's `EOC`.
- `drv_sclk`  out  1  shared shift clock.
- `drv_sin`  out  16  serial data, bit d to driver d.
- `drv_lat`  out  1  shared latch.

## Operation
- Reset (async, any state): state IDLE, column counter 0, bit counter 0, divider 0. All outputs 0.
- The FSM has five states:
  - IDLE: waits for `driver_SOF`.
  - LOAD: captures `data_in` into 16 × 48-bit shift registers. Driver d's word is {R,R,G,G,B,B}, sent MSB first (colour c expands to {c,c}).
  - SHIFT: sends 48 bits.
  - END: pulses `EOC`; also pulses `frame_done` if column = `MULTIPLEXING`−1.
  - GAP: one idle cycle so the swapped buffer settles.
- Transitions:
  - IDLE→LOAD on `driver_SOF`.
  - LOAD→SHIFT unconditionally.
  - SHIFT→END after the 48th `drv_sclk` falling edge.
  - END→GAP when column < `MULTIPLEXING`−1; column increments.
  - END→IDLE at the last column; column resets to 0.
  - GAP→LOAD unconditionally.
- Latch encoding: `drv_lat` is high while the last N bits of the 48 are shifted. N = 1 (WRTGS) for columns 0..`MULTIPLEXING`−2. N = 3 (LATGS) for the last column.
- `driver_SOF` in any state other than IDLE (resync):
  - Abort the current column and force LOAD with column = 0.
  - `drv_sclk`, `drv_lat` and `drv_sin` drop to 0 on the same edge.
  - No `EOC` is emitted for the aborted column.
- `driver_SOF` coincident with END: resync wins; no `EOC` or `frame_done` is emitted.
- Counters are sized for their range: bit counter 0..47, column counter wraps at `MULTIPLEXING`.

## Timing
- Bit k (k = 0..47) occupies 2·`SCLK_DIV` cycles:
  - `drv_sin` changes at the start of the bit with `drv_sclk` low.
  - `drv_sclk` is low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles.
  - Data is stable on every `drv_sclk` rising edge.
- `drv_lat` rises with `drv_sin` at the start of bit 48−N and falls at the end of bit 47, when `drv_sclk` falls.
- Latency with `SCLK_DIV`=2, cycle 0 = `driver_SOF` high in IDLE:
  - Cycle 1: LOAD.
  - Cycles 2..193: SHIFT (192 cycles).
  - Cycle 194: END (`EOC`=1).
  - Cycle 195: GAP.
  - Cycle 196: LOAD of the next column.
- Column period is 48·2·`SCLK_DIV` + 3 cycles. A full 8-column frame ends with `frame_done` at cycle 194 + 7·195 = 1559.
- `data_in` is sampled only on the LOAD cycle and may change at any other time.
- Outside SHIFT, `drv_sclk` = 0, `drv_lat` = 0 and `drv_sin` = 0.

## Test plan
- Single column: driver 0 pixel = 0xA5_3C_0F, others 0; pulse `driver_SOF`.
  - Required: `drv_sin[0]` shows 0xA5A5_3C3C_0F0F MSB-first across 48 `drv_sclk` rising edges.
  - Required: `drv_sin[15:1]` stays 0, `drv_lat` is high only for the last bit, and `EOC` fires at cycle 194.
- Full frame (8 columns):
  - Required: exactly 8 `EOC` pulses, 195 cycles apart.
  - Required: `drv_lat` is 1 bit wide on columns 0–6 and 3 bits wide on column 7, with `frame_done` coincident with the 8th `EOC`; the FSM then returns to IDLE.
- All 16 drivers, driver d pixel = {d,d,d}:
  - Required: each `drv_sin[d]` carries {d,d} repeated three times.
  - Required: `data_in` changed after LOAD has no effect on the shifted data.
- Resync mid-column: second `driver_SOF` at bit 20 of column 3.
  - Required: no `EOC` for column 3; restart at column 0 with a 1-bit latch; 8 further `EOC`s before `frame_done`.
- Reset mid-SHIFT: assert `rst` asynchronously.
  - Required: all outputs are 0 before the next `clk` edge.
  - Required: after release, nothing happens until `driver_SOF`.
- `SCLK_DIV`=1:
  - Required: column period is 99 cycles.
  - Required: `drv_sclk` toggles every cycle, and bit and latch alignment are unchanged.

Source files
------------

// File: rtl/driver_column_shifter.sv
// driver_column_shifter: serializes framebuffer columns onto parallel LED-driver data lines
module driver_column_shifter #(
    parameter int NB_DRIVERS   = 16,
    parameter int MULTIPLEXING = 8,
    parameter int SCLK_DIV     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [24*NB_DRIVERS-1:0] data_in,
    input  logic                    driver_SOF,
    output logic                    EOC,
    output logic                    frame_done,
    output logic                    drv_sclk,
    output logic [NB_DRIVERS-1:0]   drv_sin,
    output logic                    drv_lat
);
    localparam int CW = MULTIPLEXING > 1 ? $clog2(MULTIPLEXING) : 1;
    localparam int DW = $clog2(2 * SCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * SCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HIGH = DW'(SCLK_DIV);
    localparam logic [CW-1:0] COL_LAST = CW'(MULTIPLEXING - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, END, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] col;
    logic [5:0]    bit_cnt;
    logic [DW-1:0] div;
    logic          shifting, bit_end, last_col, stay;

    assign shifting = state == SHIFT;
    assign bit_end  = shifting && div == DIV_LAST;
    assign last_col = col == COL_LAST;
    assign stay     = shifting && state_n == SHIFT;

    // next state; driver_SOF restarts the frame from any state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = IDLE;
            LOAD:    state_n = SHIFT;
            SHIFT:   state_n = bit_end && bit_cnt == 6'd47 ? END : SHIFT;
            END:     state_n = last_col ? IDLE : GAP;
            GAP:     state_n = LOAD;
            default: state_n = IDLE;
        endcase
        if (driver_SOF) state_n = LOAD;
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    // column, bit and sclk-divider counters; divider and bit count clear outside SHIFT
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            col     <= '0;
            bit_cnt <= '0;
            div     <= '0;
        end else begin
            col     <= driver_SOF ? '0 : state == END ? (last_col ? '0 : col + 1'b1) : col;
            div     <= stay ? (bit_end ? '0 : div + 1'b1) : '0;
            bit_cnt <= stay ? (bit_end ? bit_cnt + 6'd1 : bit_cnt) : '0;
        end

    for (genvar d = 0; d < NB_DRIVERS; d++) begin : g_drv
        logic [47:0] sr;
        logic [7:0]  r, g, b;
        assign r = data_in[24*d+16 +: 8];
        assign g = data_in[24*d+8 +: 8];
        assign b = data_in[24*d +: 8];
        // per-driver word {R,R,G,G,B,B}, shifted MSB first at the end of each bit
        always_ff @(posedge clk or posedge rst)
            if (rst) sr <= '0;
            else if (state == LOAD) sr <= {r, r, g, g, b, b};
            else if (bit_end) sr <= {sr[46:0], 1'b0};
        assign drv_sin[d] = shifting & sr[47];
    end

    assign drv_sclk   = shifting && div >= DIV_HIGH;
    assign drv_lat    = shifting && bit_cnt >= (last_col ? 6'd45 : 6'd47);
    assign EOC        = state == END && !driver_SOF;
    assign frame_done = EOC && last_col;
endmodule
